// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline widths, per-stage payload structs and pointer helper
package pipe_pkg;

    localparam int ADDR_SIZE = 32;
    localparam int INST_SIZE = 32;
    localparam int DATA_SIZE = 32;
    localparam int REG_IDX_W = 5;
    localparam int CTRL_W    = 8;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] pc;
        logic [INST_SIZE-1:0] inst;
    } if_payload_t;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] pc;
        logic [DATA_SIZE-1:0] rs1_data;
        logic [DATA_SIZE-1:0] rs2_data;
        logic [DATA_SIZE-1:0] imm;
        logic [REG_IDX_W-1:0] rd;
        logic [CTRL_W-1:0]    ctrl;
    } id_payload_t;

    typedef struct packed {
        logic [DATA_SIZE-1:0] alu_result;
        logic [DATA_SIZE-1:0] store_data;
        logic [REG_IDX_W-1:0] rd;
        logic [CTRL_W-1:0]    ctrl;
    } ex_payload_t;

    typedef struct packed {
        logic [DATA_SIZE-1:0] wb_data;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_to_reg;
    } mem_payload_t;

    typedef struct packed {
        logic [DATA_SIZE-1:0] wb_data;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_write;
    } wb_payload_t;

    localparam int IF_PAYLOAD_W  = $bits(if_payload_t);
    localparam int ID_PAYLOAD_W  = $bits(id_payload_t);
    localparam int EX_PAYLOAD_W  = $bits(ex_payload_t);
    localparam int MEM_PAYLOAD_W = $bits(mem_payload_t);
    localparam int WB_PAYLOAD_W  = $bits(wb_payload_t);

    // A single-entry ring still needs a 1-bit pointer to keep port widths legal.
    function automatic int ptr_w(int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - valid/ready payload handshake between pipeline stages
interface pipe_stage_buf_if #(
    parameter int PAYLOAD_W = 64
);
    logic                 valid;
    logic                 ready;
    logic [PAYLOAD_W-1:0] payload;

    modport master (
        output valid,
        output payload,
        input  ready
    );

    modport slave (
        input  valid,
        input  payload,
        output ready
    );
endinterface

// File: rtl/pipe_ring_ptr.sv
// rtl/pipe_ring_ptr.sv - mod-DEPTH ring pointer with increment and clear
module pipe_ring_ptr
    import pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      inc,
    output logic [ptr_w(DEPTH)-1:0]   ptr
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_next;

    // Explicit wrap so non-power-of-two depths stay in range.
    always_comb begin
        ptr_next = ptr;
        if (inc) begin
            ptr_next = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end
endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - DEPTH-entry pipeline stage buffer with flush and drop counter
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 64,
    parameter int DEPTH     = 2,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    pipe_stage_buf_if.slave              in_if,
    pipe_stage_buf_if.master             out_if,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             drop_count
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 2;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [PAYLOAD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 offered;
    logic                 push;
    logic                 pop;
    logic [SUM_W-1:0]     drop_add;
    logic [SUM_W-1:0]     drop_sum;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign full    = (occupancy == OCC_FULL);
    assign empty   = (occupancy == '0);
    assign offered = in_if.valid & !full;
    assign push    = offered & !flush;
    assign pop     = !empty & out_if.ready;

    assign in_if.ready    = !full;
    assign out_if.valid   = !empty;
    assign out_if.payload = empty ? '0 : mem[rd_ptr];

    pipe_ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    pipe_ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_if.payload;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else if (push && !pop) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (pop && !push) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end

    // A head popped in the flush cycle was delivered; an accepted offer was not.
    always_comb begin
        drop_add = SUM_W'(occupancy) - SUM_W'(pop) + SUM_W'(offered);
        drop_sum = SUM_W'(drop_count) + drop_add;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (flush) begin
            drop_count <= (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - scoreboard bench for pipe_stage_buf at DEPTH 2/3 and CNT_W 8/2
module tb_pipe_stage_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       flush_s [3];
    logic       iv      [3];
    logic       ordy    [3];
    logic [7:0] idata   [3];
    logic       ir      [3];
    logic       ov      [3];
    logic [7:0] odata   [3];
    logic [1:0] occ     [3];
    logic [7:0] dc      [3];

    logic [1:0] occ0, occ1, occ2;
    logic [7:0] dc0, dc1;
    logic [1:0] dc2;

    int total = 0;
    int bad   = 0;
    int rx_cnt [3] = '{0, 0, 0};

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    pipe_stage_buf_if #(.PAYLOAD_W(8)) in_if0 ();
    pipe_stage_buf_if #(.PAYLOAD_W(8)) out_if0 ();
    pipe_stage_buf_if #(.PAYLOAD_W(8)) in_if1 ();
    pipe_stage_buf_if #(.PAYLOAD_W(8)) out_if1 ();
    pipe_stage_buf_if #(.PAYLOAD_W(8)) in_if2 ();
    pipe_stage_buf_if #(.PAYLOAD_W(8)) out_if2 ();

    assign in_if0.valid = iv[0];  assign in_if0.payload = idata[0];  assign out_if0.ready = ordy[0];
    assign in_if1.valid = iv[1];  assign in_if1.payload = idata[1];  assign out_if1.ready = ordy[1];
    assign in_if2.valid = iv[2];  assign in_if2.payload = idata[2];  assign out_if2.ready = ordy[2];
    assign ir[0] = in_if0.ready;  assign ov[0] = out_if0.valid;  assign odata[0] = out_if0.payload;
    assign ir[1] = in_if1.ready;  assign ov[1] = out_if1.valid;  assign odata[1] = out_if1.payload;
    assign ir[2] = in_if2.ready;  assign ov[2] = out_if2.valid;  assign odata[2] = out_if2.payload;
    assign occ[0] = occ0;  assign occ[1] = occ1;  assign occ[2] = occ2;
    assign dc[0] = dc0;    assign dc[1] = dc1;    assign dc[2] = {6'b0, dc2};

    pipe_stage_buf #(.PAYLOAD_W(8), .DEPTH(2), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .flush(flush_s[0]), .in_if(in_if0), .out_if(out_if0),
        .occupancy(occ0), .drop_count(dc0)
    );
    pipe_stage_buf #(.PAYLOAD_W(8), .DEPTH(3), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .flush(flush_s[1]), .in_if(in_if1), .out_if(out_if1),
        .occupancy(occ1), .drop_count(dc1)
    );
    pipe_stage_buf #(.PAYLOAD_W(8), .DEPTH(2), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .flush(flush_s[2]), .in_if(in_if2), .out_if(out_if2),
        .occupancy(occ2), .drop_count(dc2)
    );

    function automatic int depth_of(int k);
        return (k == 1) ? 3 : 2;
    endfunction

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d got=%0h want=%0h", name, k, act, exp);
        end
    endtask

    task automatic exp_push(int k, logic [7:0] v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic exp_clear(int k);
        case (k)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    function automatic int exp_size(int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic exp_pop(int k, output logic [7:0] v, output bit ok);
        ok = (exp_size(k) != 0);
        v  = 8'h00;
        if (ok) begin
            case (k)
                0: v = q0.pop_front();
                1: v = q1.pop_front();
                default: v = q2.pop_front();
            endcase
        end
    endtask

    logic [7:0] prev_data [3];
    bit         prev_hold [3];
    logic [7:0] mon_v;
    bit         mon_ok;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                chk("occ_le_depth", k, 32'(int'(occ[k]) <= depth_of(k)), 32'd1);
                chk("in_ready_vs_occ", k, 32'(ir[k]), 32'(int'(occ[k]) != depth_of(k)));
                if (prev_hold[k]) chk("hold_stable", k, 32'(odata[k]), 32'(prev_data[k]));
                if (ov[k] && ordy[k]) begin
                    exp_pop(k, mon_v, mon_ok);
                    if (!mon_ok) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out u%0d got=%0h want=none", k, odata[k]);
                    end else begin
                        chk("out_data", k, 32'(odata[k]), 32'(mon_v));
                        rx_cnt[k]++;
                    end
                end
            end
            prev_hold[k] = !rst && ov[k] && !ordy[k] && !flush_s[k];
            prev_data[k] = odata[k];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(int k, logic [7:0] v);
        chk("ready_before_push", k, 32'(ir[k]), 32'd1);
        iv[k]    = 1'b1;
        idata[k] = v;
        exp_push(k, v);
        step();
        iv[k]    = 1'b0;
        idata[k] = 8'hxx;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    int base;
    int n;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            flush_s[k] = 1'b0;
            iv[k]      = 1'b0;
            ordy[k]    = 1'b0;
            idata[k]   = 8'h00;
        end
        repeat (2) step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
            chk("rst_out_payload", k, 32'(odata[k]), 32'd0);
            chk("rst_in_ready", k, 32'(ir[k]), 32'd1);
            chk("rst_occupancy", k, 32'(occ[k]), 32'd0);
            chk("rst_drop_count", k, 32'(dc[k]), 32'd0);
        end

        // Streaming through DEPTH=2
        ordy[0] = 1'b1;
        push1(0, 8'h11);
        chk("stream_first_valid", 0, 32'(ov[0]), 32'd1);
        chk("stream_first_data", 0, 32'(odata[0]), 32'h11);
        push1(0, 8'h22);
        chk("stream_second_data", 0, 32'(odata[0]), 32'h22);
        push1(0, 8'h33);
        chk("stream_third_data", 0, 32'(odata[0]), 32'h33);
        repeat (2) step();
        chk("stream_rx_count", 0, 32'(rx_cnt[0]), 32'd3);
        chk("stream_drained_occ", 0, 32'(occ[0]), 32'd0);

        // Stall until full, then drain
        ordy[0] = 1'b0;
        push1(0, 8'h0A);
        push1(0, 8'h0B);
        chk("full_occ", 0, 32'(occ[0]), 32'd2);
        chk("full_in_ready", 0, 32'(ir[0]), 32'd0);
        chk("full_head", 0, 32'(odata[0]), 32'h0A);
        repeat (2) step();
        chk("stall_head_held", 0, 32'(odata[0]), 32'h0A);
        ordy[0] = 1'b1;
        step();
        chk("drain_second_head", 0, 32'(odata[0]), 32'h0B);
        chk("drain_occ_one", 0, 32'(occ[0]), 32'd1);
        step();
        ordy[0] = 1'b0;
        chk("drain_occ_zero", 0, 32'(occ[0]), 32'd0);
        chk("drain_in_ready", 0, 32'(ir[0]), 32'd1);
        chk("empty_bubble", 0, 32'(odata[0]), 32'd0);
        chk("drain_rx_count", 0, 32'(rx_cnt[0]), 32'd5);

        // Flush with a concurrent pop and offer on DEPTH=3
        ordy[1] = 1'b0;
        push1(1, 8'h01);
        push1(1, 8'h02);
        chk("pre_flush_occ", 1, 32'(occ[1]), 32'd2);
        ordy[1]    = 1'b1;
        iv[1]      = 1'b1;
        idata[1]   = 8'h03;
        flush_s[1] = 1'b1;
        step();
        flush_s[1] = 1'b0;
        iv[1]      = 1'b0;
        ordy[1]    = 1'b0;
        exp_clear(1);
        chk("flush_occ", 1, 32'(occ[1]), 32'd0);
        chk("flush_out_valid", 1, 32'(ov[1]), 32'd0);
        chk("flush_in_ready", 1, 32'(ir[1]), 32'd1);
        chk("flush_drop_count", 1, 32'(dc[1]), 32'd2);
        chk("flush_pop_delivered", 1, 32'(rx_cnt[1]), 32'd1);

        // Back-to-back flushes: second one sees an empty stage
        push1(1, 8'h05);
        flush_s[1] = 1'b1;
        step();
        exp_clear(1);
        chk("b2b_flush_first", 1, 32'(dc[1]), 32'd3);
        step();
        flush_s[1] = 1'b0;
        chk("b2b_flush_second", 1, 32'(dc[1]), 32'd3);
        chk("b2b_flush_occ", 1, 32'(occ[1]), 32'd0);

        // Wrap-around with random consumer gaps
        base = rx_cnt[1];
        fork
            begin
                for (int v = 1; v <= 7; v++) begin
                    iv[1]    = 1'b1;
                    idata[1] = 8'(v);
                    n = 0;
                    while (!ir[1] && n < 50) begin
                        step();
                        n++;
                    end
                    if (n >= 50) chk("wrap_push_timeout", 1, 32'(ir[1]), 32'd1);
                    exp_push(1, 8'(v));
                    step();
                end
                iv[1]    = 1'b0;
                idata[1] = 8'hxx;
            end
            begin
                repeat (30) begin
                    ordy[1] = 1'($urandom_range(0, 1));
                    step();
                end
                ordy[1] = 1'b1;
            end
        join
        n = 0;
        while (exp_size(1) != 0 && n < 50) begin
            step();
            n++;
        end
        step();
        ordy[1] = 1'b0;
        chk("wrap_rx_count", 1, 32'(rx_cnt[1] - base), 32'd7);
        chk("wrap_final_occ", 1, 32'(occ[1]), 32'd0);

        // Drop counter saturation at CNT_W=2
        for (int i = 0; i < 4; i++) begin
            ordy[2] = 1'b0;
            push1(2, 8'(8'h40 + 2 * i));
            push1(2, 8'(8'h41 + 2 * i));
            chk("sat_prefill_occ", 2, 32'(occ[2]), 32'd2);
            iv[2]      = (i == 0);
            idata[2]   = 8'h77;
            flush_s[2] = 1'b1;
            step();
            flush_s[2] = 1'b0;
            iv[2]      = 1'b0;
            exp_clear(2);
            chk("sat_drop_count", 2, 32'(dc[2]), (i == 0) ? 32'd2 : 32'd3);
        end

        // Reset mid-fill
        push1(2, 8'h55);
        chk("midfill_occ", 2, 32'(occ[2]), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) exp_clear(k);
        chk("midrst_occ", 2, 32'(occ[2]), 32'd0);
        chk("midrst_drop_count", 2, 32'(dc[2]), 32'd0);
        chk("midrst_out_valid", 2, 32'(ov[2]), 32'd0);
        chk("midrst_in_ready", 2, 32'(ir[2]), 32'd1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised pipeline-stage buffer that generalises the fixed per-stage pipeline registers (IF/ID/EX/MEM/WB) into one reusable block.
- Carries an opaque payload of PAYLOAD_W bits through a DEPTH-entry circular buffer.
- Uses a valid/ready handshake in place of the global stall flag.
- Provides a synchronous flush (branch kill) that empties the stage and counts discarded entries.
- Sits between any two pipeline stages; the producer drives in_*, the consumer drives out_ready.

Parameters:
PAYLOAD_W, 64, payload width in bits (e.g. `ADDR_SIZE + `INST_SIZE for the IF stage)
DEPTH, 2, number of buffer entries; legal range 1..16; DEPTH>=2 is required for full throughput
CNT_W, 8, width of the saturating drop counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  kill all buffered and incoming entries this cycle (branch_flag)
in_valid  in  1  producer has payload
in_ready  out  1  buffer can accept; equals !full, driven from registered state only
in_payload  in  PAYLOAD_W  producer payload
out_valid  out  1  head entry valid; equals !empty
out_ready  in  1  consumer accepts head (stall = !out_ready)
out_payload  out  PAYLOAD_W  head entry; all-zero (bubble) when out_valid=0
occupancy  out  $clog2(DEPTH+1)  number of valid entries
drop_count  out  CNT_W  saturating count of entries discarded by flush

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_ptr, rd_ptr and occupancy are 0; drop_count is 0.
  - out_valid=0, out_payload=0, in_ready=1 after the edge.
  - rst overrides flush and both handshakes; entry storage contents are don't-care.
- Push: in_valid & in_ready & !flush. Writes mem[wr_ptr]; wr_ptr = (wr_ptr+1) mod DEPTH (explicit wrap; DEPTH need not be a power of 2).
- Pop: out_valid & out_ready. rd_ptr = (rd_ptr+1) mod DEPTH.
- Latency: an entry pushed at edge N appears on out_* after edge N (visible in cycle N+1). There is no same-cycle input-to-output bypass.
- Simultaneous push and pop:
  - Occupancy is unchanged and both pointers advance.
  - When full, in_ready=0 regardless of out_ready, so there is no combinational path from out_ready to in_ready.
  - DEPTH=1 therefore sustains 1 transfer every 2 cycles; DEPTH>=2 sustains 1 per cycle.
- Full (occupancy==DEPTH): in_ready=0; in_payload is ignored.
- Empty (occupancy==0): out_valid=0; out_payload=0; out_ready is ignored.
- Flush (flush=1, rst=0), at the edge:
  - Occupancy, wr_ptr and rd_ptr all go to 0.
  - A pop handshake in the flush cycle counts as delivered and is not a drop.
  - An input offered with in_valid & in_ready in the flush cycle is discarded and counts as a drop.
  - drop_count += (occupancy - pop_this_cycle) + (in_valid & in_ready), saturating at 2^CNT_W-1.
  - Next cycle: out_valid=0, in_ready=1.
- Back-to-back flushes are legal; each one counts only the entries present in its own cycle.
- Payload values are never interpreted; X on in_payload while in_valid=0 must not propagate to out_payload.
- Assertions (bench-side):
  - occupancy<=DEPTH.
  - out_payload stable while out_valid & !out_ready & !flush.
  - in_ready==(occupancy!=DEPTH).

Decomposition:
- Shared package pipe_pkg:
  - `ADDR_SIZE/`INST_SIZE/`DATA_SIZE-derived localparams.
  - Packed struct typedefs per stage payload (if_payload_t, id_payload_t, ex_payload_t, mem_payload_t, wb_payload_t), so that PAYLOAD_W = $bits(<stage>_payload_t).
- Sub-module pipe_ring_ptr (parameter DEPTH): a mod-DEPTH pointer with inc and clr inputs, instantiated twice (wr, rd).

Test Plan:
- Reset then idle, DEPTH=2: rst=1 for 2 cycles, then drop it → out_valid=0, out_payload=0, in_ready=1, occupancy=0, drop_count=0.
- Streaming, DEPTH=2: push 0x11,0x22,0x33 on consecutive cycles with out_ready=1 → outputs 0x11,0x22,0x33 in cycles 1,2,3 after each push; in_ready stays 1.
- Stall/full, DEPTH=2, out_ready=0: push 0xA,0xB → occupancy=2, in_ready=0, out_payload holds 0xA. Raise out_ready → 0xA then 0xB drain; in_ready returns to 1.
- Flush with concurrent traffic: occupancy=2 (0x1,0x2), then in one cycle pop 0x1, offer 0x3 and assert flush → next cycle occupancy=0, out_valid=0, drop_count=2.
- Wrap-around, DEPTH=3: push/pop 7 entries (values 1..7) with random out_ready gaps → FIFO order preserved through pointer wrap; occupancy never exceeds 3.
- Saturation, CNT_W=2: four flushes, each with 2 entries buffered → drop_count=3 and it holds. Reset mid-fill (occupancy=1) → occupancy=0 and drop_count=0 on the next cycle.
